// File: rtl/sop_pos_selftest_ctrl.sv
// Self-test sequencer for the 4-input minterm/maxterm function block.
// It sweeps every input vector, lets each one settle, compares the SOP and POS outputs against the reference, and records the results.
module sop_pos_selftest_ctrl #(
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [2:0]   fn_out,
  output logic [W-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err_min,
  output logic         err_max,
  output logic [W-1:0] fail_vec,
  output logic [W:0]   fail_cnt,
  output logic [1:0]   state_dbg
);

  // Handshake: start and abort are plain levels sampled at each rising edge.
  // A sweep is accepted only when the block is not busy, and abort has priority over start.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int          SETTLE_EFF  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_EFF - 1);
  localparam logic [W-1:0] VEC_LAST   = {W{1'b1}};

  state_t     state_q, state_d;
  logic [7:0] cnt;
  logic       m0, m1;

  assign m0        = fn_out[0] ^ fn_out[1];
  assign m1        = fn_out[0] ^ fn_out[2];
  assign pass      = done && (fail_cnt == '0);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (cnt == SETTLE_LAST) state_d = CHECK;
      CHECK:      state_d = (vec == VEC_LAST) ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_min  <= 1'b0;
      err_max  <= 1'b0;
      fail_vec <= '0;
      fail_cnt <= '0;
    end else if (abort) begin
      vec      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_min  <= 1'b0;
      err_max  <= 1'b0;
      fail_vec <= '0;
      fail_cnt <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err_min  <= 1'b0;
            err_max  <= 1'b0;
            fail_vec <= '0;
            fail_cnt <= '0;
          end
        end
        SETTLE: begin
          if (cnt != SETTLE_LAST) cnt <= cnt + 8'd1;
        end
        CHECK: begin
          if (m0) err_min <= 1'b1;
          if (m1) err_max <= 1'b1;
          // A vector that fails both forms counts once; the first failing vector is latched while the count is still zero.
          if (m0 || m1) begin
            fail_cnt <= fail_cnt + 1'b1;
            if (fail_cnt == '0) fail_vec <= vec;
          end
          if (vec == VEC_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            vec <= vec + 1'b1;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sop_pos_selftest_ctrl.md
Name: sop_pos_selftest_ctrl

Overview:
Self-test sequencer for the 4-input minterm/maxterm logic function block. It sweeps every input vector into the function block's switch inputs and waits a programmable settle time. It then samples the three function outputs: reference, minterm (SOP) and maxterm (POS). Results are mismatch flags, a failure count and the first failing vector, which sit between the board-level start button and the function block's LED outputs.

Parameters:
W, 4, width of the input vector driven to the function block; the sweep covers 2^W vectors.
SETTLE_CYCLES, 4, clocks each vector is held before sampling; legal range 1..255 (0 behaves as 1).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  synchronous request to begin a sweep; level sampled at a rising edge.
abort  input  1  synchronous request to stop the sweep and clear results.
fn_out  input  3  function block outputs: [0] reference, [1] minterm form, [2] maxterm form.
vec  output  W  vector driven to the function block switch inputs.
busy  output  1  high while a sweep is in progress.
done  output  1  high once a sweep completes; held until the next start or abort.
pass  output  1  equals done AND (fail_cnt == 0).
err_min  output  1  sticky flag: fn_out[0] != fn_out[1] at some checked vector.
err_max  output  1  sticky flag: fn_out[0] != fn_out[2] at some checked vector.
fail_vec  output  W  first vector at which either mismatch occurred; 0 if none.
fail_cnt  output  W+1  number of vectors with any mismatch, range 0..2^W.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; vec, busy, done, pass, err_min, err_max, fail_vec, fail_cnt and the settle counter all 0.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: vec=0, busy=0. On start=1 → SETTLE. At the same edge: vec←0, settle counter←0, all result registers cleared, done←0.
- SETTLE: busy=1. vec is held for exactly SETTLE_CYCLES clocks, then → CHECK.
- CHECK (1 clock):
  - fn_out is sampled in this state. m0 = fn_out[0]^fn_out[1]; m1 = fn_out[0]^fn_out[2].
  - If m0, err_min←1. If m1, err_max←1.
  - If m0|m1: fail_cnt←fail_cnt+1. If this is the first failure since start, fail_vec←vec.
  - A vector with both mismatches counts once.
  - If vec == 2^W-1 → DONE. Otherwise vec←vec+1, counter←0, → SETTLE.
- DONE: busy=0, done=1. vec holds 2^W-1. Results hold. start=1 → new sweep, same as from IDLE, clearing results.
- Timing: each vector occupies SETTLE_CYCLES+1 clocks. If start is sampled at edge E0, done rises after edge E0 + 2^W*(SETTLE_CYCLES+1). Default case is 80 clocks.
- vec never wraps: the sweep ends at 2^W-1; fail_cnt cannot overflow.
- start while busy: ignored.
- abort in any state: → IDLE next edge, all outputs cleared as at reset, but synchronously.
- start and abort in the same cycle: abort wins.
- Asynchronous reset mid-sweep: outputs go to reset values immediately, with no partial results retained.
- All outputs are registered, with no combinational path from fn_out to any output. pass is derived from registered done and fail_cnt.

Test Plan:
1. Reset, then start with a matching function block (fn_out all equal, every vector), SETTLE_CYCLES=4 → vec steps 0..15, each value held 5 clocks. done=1 and pass=1 exactly 80 clocks after start; fail_cnt=0, err_min=err_max=0, fail_vec=0.
2. Model forces fn_out[1] inverted only at vec=5 → done after 80 clocks; pass=0, fail_cnt=1, fail_vec=5, err_min=1, err_max=0.
3. Model inverts fn_out[1] and fn_out[2] at vec=3, and only fn_out[2] at vec=9 → fail_cnt=2, fail_vec=3, err_min=1, err_max=1.
4. Start, then pulse start again at clock 20 → sweep unaffected; done still at clock 80. From DONE, a start pulse clears results and reruns the sweep; a second matching run ends with pass=1.
5. Start; assert abort at clock 30, with start also high that cycle → next edge: busy=0, vec=0, done=0, fail_cnt=0, and no done ever asserts.
6. Start; drop rst_n asynchronously mid-cycle at clock 42 → all outputs 0 immediately. After release, a fresh start completes normally in 80 clocks.
